// File: rtl/midi_pkg.sv
// Shared types, constants and byte helpers for the MIDI message parser.
package midi_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_D1,
    S_D2,
    S_SYSEX
  } state_e;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [1:0] len;
  } msg_t;

  localparam logic [7:0] ST_SYSEX = 8'hF0;
  localparam logic [7:0] ST_EOX   = 8'hF7;
  localparam logic [7:0] ST_TUNE  = 8'hF6;

  function automatic logic is_status(input logic [7:0] b);
    return b[7];
  endfunction

  // Data bytes and undefined/realtime codes report zero length.
  function automatic logic [1:0] data_len(input logic [7:0] st);
    logic [1:0] n;
    unique case (st[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd2;
      4'hC, 4'hD: n = 2'd1;
      4'hF: begin
        unique case (st[3:0])
          4'h2: n = 2'd2;
          4'h1, 4'h3: n = 2'd1;
          default: n = 2'd0;
        endcase
      end
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// FIFO-side and message-side signals of the MIDI message parser.
interface midi_msg_parser_if #(
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [7:0]           fifo_dout;
  logic                 msg_valid;
  logic                 msg_ready;
  logic [7:0]           msg_status;
  logic [7:0]           msg_data1;
  logic [7:0]           msg_data2;
  logic [1:0]           msg_len;
  logic                 sysex_active;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    input  fifo_empty, fifo_dout, msg_ready,
    output fifo_rd_en, msg_valid, msg_status,
    output msg_data1, msg_data2, msg_len,
    output sysex_active, err_count
  );

  modport slave (
    output fifo_empty, fifo_dout, msg_ready,
    input  fifo_rd_en, msg_valid, msg_status,
    input  msg_data1, msg_data2, msg_len,
    input  sysex_active, err_count
  );
endinterface

// File: rtl/midi_byte_classifier.sv
// Combinational decode of one MIDI byte into its protocol class.
module midi_byte_classifier
  import midi_pkg::*;
(
  input  logic [7:0] b_i,
  output logic       is_status_o,
  output logic       is_realtime_o,
  output logic       is_undef_o,
  output logic [1:0] data_len_o
);
  assign is_status_o   = is_status(b_i);
  assign is_realtime_o = (b_i[7:3] == 5'b11111);
  assign is_undef_o    = (b_i == 8'hF4) || (b_i == 8'hF5);
  assign data_len_o    = data_len(b_i);
endmodule

// File: rtl/midi_msg_parser.sv
// Pops MIDI bytes from the data FIFO and assembles complete messages
// with running status, one message at a time on a valid/ready bus.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int unsigned RUNNING_STATUS_EN = 1,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  midi_msg_parser_if.master bus
);
  state_e state_q, state_d;
  logic byte_vld_q;
  logic rd_en;
  logic rs_en;
  logic [7:0] b;
  logic b_status, b_rt, b_undef;
  logic [1:0] b_len;
  logic [7:0] status_q, status_d;
  logic [1:0] len_q, len_d;
  logic [7:0] data1_q, data1_d;
  logic [7:0] run_q, run_d;
  logic run_vld_q, run_vld_d;
  logic sysex_q, sysex_d;
  logic msg_valid_q, msg_valid_d;
  msg_t msg_q, msg_d;
  logic emit;
  logic [1:0] err_inc;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [ERR_CNT_W:0] err_sum;

  assign rs_en = (RUNNING_STATUS_EN != 0);
  assign b = bus.fifo_dout;

  // Pop only into a free (or freeing) slot, never back-to-back.
  assign rd_en = !rst && !bus.fifo_empty && !byte_vld_q
              && (!msg_valid_q || bus.msg_ready);

  midi_byte_classifier u_cls (
    .b_i          (b),
    .is_status_o  (b_status),
    .is_realtime_o(b_rt),
    .is_undef_o   (b_undef),
    .data_len_o   (b_len)
  );

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    len_d       = len_q;
    data1_d     = data1_q;
    run_d       = run_q;
    run_vld_d   = run_vld_q;
    sysex_d     = sysex_q;
    msg_valid_d = msg_valid_q;
    msg_d       = msg_q;
    emit        = 1'b0;
    err_inc     = 2'd0;
    if (msg_valid_q && bus.msg_ready) begin
      msg_valid_d = 1'b0;
    end
    if (byte_vld_q && !b_rt) begin
      if (b_status) begin
        if ((state_q == S_D1 || state_q == S_D2) && b != ST_EOX) begin
          err_inc = err_inc + 2'd1;
        end
        state_d   = S_IDLE;
        sysex_d   = 1'b0;
        run_vld_d = 1'b0;
        if (b == ST_SYSEX) begin
          state_d = S_SYSEX;
          sysex_d = 1'b1;
        end else if (b == ST_EOX) begin
          if (state_q != S_SYSEX) begin
            err_inc = err_inc + 2'd1;
          end
        end else if (b_undef) begin
          err_inc = err_inc + 2'd1;
        end else if (b == ST_TUNE) begin
          emit         = 1'b1;
          msg_d.status = b;
          msg_d.data1  = 8'h00;
          msg_d.data2  = 8'h00;
          msg_d.len    = 2'd0;
        end else begin
          status_d = b;
          len_d    = b_len;
          state_d  = S_D1;
          if (b[7:4] != 4'hF) begin
            run_d     = b;
            run_vld_d = 1'b1;
          end
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (rs_en && run_vld_q) begin
              status_d = run_q;
              len_d    = data_len(run_q);
              if (data_len(run_q) == 2'd1) begin
                emit         = 1'b1;
                msg_d.status = run_q;
                msg_d.data1  = b;
                msg_d.data2  = 8'h00;
                msg_d.len    = 2'd1;
              end else begin
                data1_d = b;
                state_d = S_D2;
              end
            end else begin
              err_inc = 2'd1;
            end
          end
          S_D1: begin
            if (len_q == 2'd1) begin
              emit         = 1'b1;
              msg_d.status = status_q;
              msg_d.data1  = b;
              msg_d.data2  = 8'h00;
              msg_d.len    = 2'd1;
              state_d      = S_IDLE;
            end else begin
              data1_d = b;
              state_d = S_D2;
            end
          end
          S_D2: begin
            emit         = 1'b1;
            msg_d.status = status_q;
            msg_d.data1  = data1_q;
            msg_d.data2  = b;
            msg_d.len    = 2'd2;
            state_d      = S_IDLE;
          end
          S_SYSEX: ;
        endcase
      end
    end
    if (emit) begin
      msg_valid_d = 1'b1;
      if (msg_d.status[7:4] != 4'hF) begin
        run_d     = msg_d.status;
        run_vld_d = 1'b1;
      end
    end
    err_sum = {1'b0, err_q} + {{(ERR_CNT_W-1){1'b0}}, err_inc};
    err_d   = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_vld_q  <= 1'b0;
      status_q    <= 8'h00;
      len_q       <= 2'd0;
      data1_q     <= 8'h00;
      run_q       <= 8'h00;
      run_vld_q   <= 1'b0;
      sysex_q     <= 1'b0;
      msg_valid_q <= 1'b0;
      msg_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      byte_vld_q  <= rd_en;
      status_q    <= status_d;
      len_q       <= len_d;
      data1_q     <= data1_d;
      run_q       <= run_d;
      run_vld_q   <= run_vld_d;
      sysex_q     <= sysex_d;
      msg_valid_q <= msg_valid_d;
      msg_q       <= msg_d;
      err_q       <= err_d;
    end
  end

  assign bus.fifo_rd_en   = rd_en;
  assign bus.msg_valid    = msg_valid_q;
  assign bus.msg_status   = msg_q.status;
  assign bus.msg_data1    = msg_q.data1;
  assign bus.msg_data2    = msg_q.data2;
  assign bus.msg_len      = msg_q.len;
  assign bus.sysex_active = sysex_q;
  assign bus.err_count    = err_q;
endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: FIFO model, byte-stream reference parser,
// per-cycle compare, plus directed literal scenarios.
module tb_midi_msg_parser;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  midi_msg_parser_if #(.ERR_CNT_W(8)) bus ();

  midi_msg_parser #(
    .RUNNING_STATUS_EN(1),
    .ERR_CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // FIFO model
  logic [7:0] fmem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic pop_req = 1'b0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (pop_req) begin
      bus.fifo_dout <= fmem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr] = b;
    wr_ptr++;
  endtask

  // Reference parser over the byte stream
  int mstat, mrun, nd, merr;
  bit msx;
  logic [7:0] dbuf0, dbuf1;
  logic [25:0] expq [$];

  function automatic int len_of(input int s);
    if (s >= 8'h80 && s < 8'hC0) return 2;
    if (s >= 8'hC0 && s < 8'hE0) return 1;
    if (s >= 8'hE0 && s < 8'hF0) return 2;
    if (s == 8'hF2) return 2;
    if (s == 8'hF1 || s == 8'hF3) return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    mstat = -1; mrun = -1; nd = 0; merr = 0; msx = 0;
    expq.delete();
  endfunction

  function automatic void emit(input int s, input logic [7:0] d1,
                               input logic [7:0] d2, input int l);
    logic [7:0] st;
    logic [1:0] ln;
    st = s[7:0];
    ln = l[1:0];
    expq.push_back({st, d1, d2, ln});
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int bi;
    bi = int'(b);
    if (bi >= 8'hF8) return;
    if (bi >= 8'h80) begin
      if (!msx && mstat >= 0 && bi != 8'hF7) merr++;
      mstat = -1;
      nd = 0;
      if (bi == 8'hF0) begin
        msx = 1; mrun = -1;
      end else if (bi == 8'hF7) begin
        if (!msx) merr++;
        msx = 0; mrun = -1;
      end else begin
        msx = 0;
        if (bi == 8'hF4 || bi == 8'hF5) begin
          merr++; mrun = -1;
        end else if (bi >= 8'hF0) begin
          mrun = -1;
          if (len_of(bi) == 0) emit(bi, 8'h00, 8'h00, 0);
          else mstat = bi;
        end else begin
          mrun = bi; mstat = bi;
        end
      end
    end else begin
      if (msx) return;
      if (mstat < 0) begin
        if (mrun >= 0) begin
          mstat = mrun; nd = 0;
        end else begin
          merr++;
          return;
        end
      end
      if (nd == 0) dbuf0 = b; else dbuf1 = b;
      nd++;
      if (nd == len_of(mstat)) begin
        emit(mstat, dbuf0, (nd == 2) ? dbuf1 : 8'h00, nd);
        if (mstat < 8'hF0) mrun = mstat;
        mstat = -1;
        nd = 0;
      end
    end
  endfunction

  // Per-cycle compare and model advance
  bit mon_en = 0;
  bit pop_prev = 0;
  bit valid_prev = 0;
  bit sysex_seen = 0;
  logic [7:0] pop_byte;
  int cyc = 0;
  int pops = 0;
  int last_pop_cyc = 0;
  int first_cyc = 0;
  logic [25:0] got [$];
  int got_lat [$];

  always @(negedge clk) begin
    bit exp_v;
    bit exp_rd;
    int exp_err;
    cyc++;
    exp_v = (expq.size() != 0);
    exp_rd = !rst && !bus.fifo_empty && !pop_prev
          && (!exp_v || bus.msg_ready);
    exp_err = (merr > 255) ? 255 : merr;
    if (mon_en) begin
      chk("msg_valid", bus.msg_valid, exp_v);
      if (exp_v) begin
        chk("msg_status", bus.msg_status, expq[0][25:18]);
        chk("msg_data1", bus.msg_data1, expq[0][17:10]);
        chk("msg_data2", bus.msg_data2, expq[0][9:2]);
        chk("msg_len", bus.msg_len, expq[0][1:0]);
      end
      chk("err_count", bus.err_count, exp_err);
      chk("sysex_active", bus.sysex_active, msx);
      chk("fifo_rd_en", bus.fifo_rd_en, exp_rd);
    end
    if (bus.sysex_active) sysex_seen = 1;
    if (bus.msg_valid && !valid_prev) first_cyc = cyc;
    if (bus.msg_valid && bus.msg_ready) begin
      got.push_back({bus.msg_status, bus.msg_data1, bus.msg_data2,
                     bus.msg_len});
      got_lat.push_back(first_cyc - last_pop_cyc);
    end
    if (bus.fifo_rd_en) begin
      last_pop_cyc = cyc;
      pops++;
    end
    if (rst) begin
      model_reset();
      pop_prev = 0;
    end else begin
      if (bus.msg_valid && bus.msg_ready && expq.size() != 0)
        void'(expq.pop_front());
      if (pop_prev) model_byte(pop_byte);
      pop_prev = bus.fifo_rd_en;
      if (bus.fifo_rd_en) pop_byte = fmem[rd_ptr];
    end
    pop_req = bus.fifo_rd_en;
    valid_prev = bus.msg_valid;
  end

  task automatic wait_idle(input int budget);
    int quiet;
    quiet = 0;
    for (int i = 0; i < budget && quiet < 3; i++) begin
      @(negedge clk);
      if (bus.fifo_empty && !bus.msg_valid && !bus.fifo_rd_en
          && !dut.byte_vld_q)
        quiet++;
      else
        quiet = 0;
    end
    chk("idle_timeout", (quiet >= 3), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return 8'($urandom_range(8'h00, 8'h7F));
    if (r < 85) return 8'($urandom_range(8'h80, 8'hEF));
    if (r < 95) return 8'($urandom_range(8'hF0, 8'hF7));
    return 8'($urandom_range(8'hF8, 8'hFF));
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.msg_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;

    @(negedge clk);
    chk("rst_msg_valid", bus.msg_valid, 0);
    chk("rst_err", bus.err_count, 0);
    chk("rst_sysex", bus.sysex_active, 0);
    chk("rst_status", bus.msg_status, 0);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    @(posedge clk);
    #1;

    // note-on
    got.delete(); got_lat.delete();
    push(8'h90); push(8'h3C); push(8'h64);
    wait_idle(200);
    chk("noteon_n", got.size(), 1);
    chk("noteon_msg", got[0], {8'h90, 8'h3C, 8'h64, 2'd2});
    chk("noteon_lat", got_lat[0], 2);
    chk("noteon_err", bus.err_count, 0);

    // running status
    got.delete();
    push(8'h90); push(8'h3C); push(8'h64); push(8'h3E); push(8'h00);
    wait_idle(200);
    chk("run_n", got.size(), 2);
    chk("run_m0", got[0], {8'h90, 8'h3C, 8'h64, 2'd2});
    chk("run_m1", got[1], {8'h90, 8'h3E, 8'h00, 2'd2});
    chk("run_err", bus.err_count, 0);

    // program change then tune request
    got.delete();
    push(8'hC5); push(8'h07); push(8'hF6);
    wait_idle(200);
    chk("pc_n", got.size(), 2);
    chk("pc_m0", got[0], {8'hC5, 8'h07, 8'h00, 2'd1});
    chk("pc_m1", got[1], {8'hF6, 8'h00, 8'h00, 2'd0});

    // sysex, orphan data, note-off
    got.delete();
    sysex_seen = 0;
    push(8'hF0); push(8'h7E); push(8'h01); push(8'hF7);
    push(8'h41);
    push(8'h80); push(8'h40); push(8'h00);
    wait_idle(200);
    chk("sx_seen", sysex_seen, 1);
    chk("sx_end", bus.sysex_active, 0);
    chk("sx_err", bus.err_count, 1);
    chk("sx_n", got.size(), 1);
    chk("sx_m0", got[0], {8'h80, 8'h40, 8'h00, 2'd2});

    // truncated message
    got.delete();
    push(8'h90); push(8'h3C); push(8'hB0); push(8'h07); push(8'h7F);
    wait_idle(200);
    chk("tr_err", bus.err_count, 2);
    chk("tr_n", got.size(), 1);
    chk("tr_m0", got[0], {8'hB0, 8'h07, 8'h7F, 2'd2});

    // backpressure
    got.delete();
    bus.msg_ready = 1'b0;
    begin
      int p0;
      p0 = pops;
      push(8'h90); push(8'h3C); push(8'h64);
      push(8'h3E); push(8'h00); push(8'hF6);
      repeat (20) @(posedge clk);
      #1;
      chk("bp_pops", pops - p0, 3);
      chk("bp_valid", bus.msg_valid, 1);
      chk("bp_status", bus.msg_status, 8'h90);
    end
    bus.msg_ready = 1'b1;
    wait_idle(200);
    chk("bp_n", got.size(), 3);
    chk("bp_m0", got[0], {8'h90, 8'h3C, 8'h64, 2'd2});
    chk("bp_m1", got[1], {8'h90, 8'h3E, 8'h00, 2'd2});
    chk("bp_m2", got[2], {8'hF6, 8'h00, 8'h00, 2'd0});

    // reset mid-message
    got.delete();
    push(8'h90); push(8'h3C);
    wait_idle(200);
    do_reset();
    @(negedge clk);
    chk("mr_err", bus.err_count, 0);
    chk("mr_valid", bus.msg_valid, 0);
    @(posedge clk);
    #1;
    push(8'h3C);
    wait_idle(200);
    chk("mr_err1", bus.err_count, 1);
    push(8'h64);
    wait_idle(200);
    chk("mr_err2", bus.err_count, 2);
    chk("mr_n", got.size(), 0);

    // error counter saturation
    push(8'hF7);
    for (int i = 0; i < 260; i++) push(8'h00);
    wait_idle(2000);
    chk("sat_err", bus.err_count, 8'hFF);
    do_reset();
    @(negedge clk);
    chk("sat_rst", bus.err_count, 0);
    @(posedge clk);
    #1;

    // randomized stream with random backpressure
    for (int i = 0; i < 1500; i++) push(rand_byte());
    for (int i = 0; i < 30000 && wr_ptr != rd_ptr; i++) begin
      @(posedge clk);
      #1;
      bus.msg_ready = ($urandom_range(0, 3) != 0);
    end
    bus.msg_ready = 1'b1;
    wait_idle(200);
    chk("rand_drained", rd_ptr, wr_ptr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
